tf32_from_fp32_cvt: RTL and testbench

Streaming FP32-to-TF32 converter that produces the 19-bit TF32 operands consumed by the team's TF32 arithmetic (add/mul) datapath. It accepts one FP32 word per cycle on a valid/ready interface and rounds the mantissa 23→10 bits, round-to-nearest-even. It applies the datapath's number-class rules: no INF/NaN/subnormal, zeros normalised to +0. The block has a 2-stage registered pipeline with full backpressure support.

---
 rtl/tf32_pkg.sv | 43 ++++
 rtl/tf32_rne_round.sv | 40 ++++
 rtl/tf32_from_fp32_cvt.sv | 256 +++++++++++++++++++++++++
 tb/tb_tf32_from_fp32_cvt.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tf32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tf32_pkg
// Description : Shared widths, constants, field structs and number classes
//               for the FP32 -> TF32 conversion and TF32 arithmetic datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package tf32_pkg;

    localparam int FP32_W     = 32;
    localparam int TF32_W     = 19;
    localparam int EXP_W      = 8;
    localparam int TF32_MAN_W = 10;
    localparam int FP32_MAN_W = 23;

    // Number of FP32 mantissa bits discarded when narrowing to TF32.
    localparam int DROP_W     = FP32_MAN_W - TF32_MAN_W;

    localparam logic [EXP_W-1:0]      TF32_MAX_EXP  = 8'hFE;
    localparam logic [TF32_MAN_W-1:0] TF32_MAX_MAN  = 10'h3FF;
    localparam logic [TF32_W-1:0]     TF32_POS_ZERO = 19'h0;

    typedef struct packed {
        logic                  sign;
        logic [EXP_W-1:0]      exp;
        logic [FP32_MAN_W-1:0] man;
    } fp32_t;

    typedef struct packed {
        logic                  sign;
        logic [EXP_W-1:0]      exp;
        logic [TF32_MAN_W-1:0] man;
    } tf32_t;

    // Datapath number classes: subnormals fold into ZERO, INF/NaN into SPECIAL.
    typedef enum logic [1:0] {
        CLS_NORMAL  = 2'd0,
        CLS_ZERO    = 2'd1,
        CLS_SPECIAL = 2'd2
    } num_class_e;

endpackage : tf32_pkg
`default_nettype wire

// File: rtl/tf32_rne_round.sv
`default_nettype none
// ============================================================================
// Module      : tf32_rne_round
// Description : Combinational round-to-nearest-even of a 10-bit TF32 mantissa
//               given its lsb, guard and sticky bits.
//   i_man      10-bit truncated mantissa
//   i_lsb      mantissa lsb (tie-break bit)
//   i_guard    first discarded bit
//   i_sticky   OR of all remaining discarded bits
//   o_man      rounded mantissa (zero when o_carry is set)
//   o_carry    mantissa overflowed; caller increments the exponent
//   o_inexact  any discarded bit was non-zero
// Revision    : 1.0 - initial release
// ============================================================================
module tf32_rne_round
    import tf32_pkg::*;
(
    input  logic [TF32_MAN_W-1:0] i_man,
    input  logic                  i_lsb,
    input  logic                  i_guard,
    input  logic                  i_sticky,
    output logic [TF32_MAN_W-1:0] o_man,
    output logic                  o_carry,
    output logic                  o_inexact
);

    logic                w_round_up;
    logic [TF32_MAN_W:0] w_mant11;

    // Round up above half, or exactly at half when the kept lsb is odd.
    assign w_round_up = i_guard & (i_sticky | i_lsb);
    assign w_mant11   = {1'b0, i_man} + {{TF32_MAN_W{1'b0}}, w_round_up};

    // On carry-out the low bits are all zero, which is the required mantissa.
    assign o_man      = w_mant11[TF32_MAN_W-1:0];
    assign o_carry    = w_mant11[TF32_MAN_W];
    assign o_inexact  = i_guard | i_sticky;

endmodule : tf32_rne_round
`default_nettype wire

// File: rtl/tf32_from_fp32_cvt.sv
`default_nettype none
// ============================================================================
// Module      : tf32_from_fp32_cvt
// Description : Two-stage streaming FP32 -> TF32 converter (RNE rounding,
//               no INF/NaN/subnormal; specials and overflow saturate to max
//               finite, zeros/subnormals flush to zero) with valid/ready
//               backpressure on both sides.
//   clk, rst          clock and synchronous active-high reset
//   in_valid/ready    input handshake; in_data is an FP32 word
//   out_valid/ready   output handshake; out_data is a TF32 word
//   out_inexact       discarded mantissa bits were non-zero
//   out_sat           result saturated to max finite
//   Optional (TF32_CVT_STATS_EN): cnt_clr input, saturating cnt_words,
//   cnt_inexact, cnt_sat counters of output handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tf32_from_fp32_cvt
    import tf32_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter bit KEEP_ZERO_SIGN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP32_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TF32_W-1:0] out_data,
    output logic              out_inexact,
`ifdef TF32_CVT_STATS_EN
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_words,
    output logic [CNT_W-1:0]  cnt_inexact,
    output logic [CNT_W-1:0]  cnt_sat,
`endif
    output logic              out_sat
);

    // ------------------------------------------------------------------
    // Stage enables
    // ------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic w_s1_en;
    logic w_s2_en;

    assign w_s2_en  = !out_valid_q || out_ready;
    assign w_s1_en  = !s1_valid_q || w_s2_en;
    assign in_ready = w_s1_en;

    // ------------------------------------------------------------------
    // Stage 1: classify and capture rounding inputs
    // ------------------------------------------------------------------
    fp32_t                 w_in;
    logic                  s1_sign_q,   s1_sign_d;
    logic [EXP_W-1:0]      s1_exp_q,    s1_exp_d;
    logic [TF32_MAN_W-1:0] s1_man_q,    s1_man_d;
    logic                  s1_lsb_q,    s1_lsb_d;
    logic                  s1_guard_q,  s1_guard_d;
    logic                  s1_sticky_q, s1_sticky_d;
    logic                  s1_mnz_q,    s1_mnz_d;
    num_class_e            s1_cls_q,    s1_cls_d;

    assign w_in = fp32_t'(in_data);

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_exp_d    = s1_exp_q;
        s1_man_d    = s1_man_q;
        s1_lsb_d    = s1_lsb_q;
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
        s1_mnz_d    = s1_mnz_q;
        s1_cls_d    = s1_cls_q;
        if (w_s1_en) begin
            s1_valid_d = in_valid;
        end
        if (w_s1_en && in_valid) begin
            s1_sign_d   = w_in.sign;
            s1_exp_d    = w_in.exp;
            s1_man_d    = w_in.man[FP32_MAN_W-1:DROP_W];
            s1_lsb_d    = w_in.man[DROP_W];
            s1_guard_d  = w_in.man[DROP_W-1];
            s1_sticky_d = |w_in.man[DROP_W-2:0];
            // Needed only for the zero class, where all 23 bits are dropped.
            s1_mnz_d    = |w_in.man;
            if (w_in.exp == '0) begin
                s1_cls_d = CLS_ZERO;
            end else if (w_in.exp == '1) begin
                s1_cls_d = CLS_SPECIAL;
            end else begin
                s1_cls_d = CLS_NORMAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_man_q    <= '0;
            s1_lsb_q    <= 1'b0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_mnz_q    <= 1'b0;
            s1_cls_q    <= CLS_ZERO;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_man_q    <= s1_man_d;
            s1_lsb_q    <= s1_lsb_d;
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
            s1_mnz_q    <= s1_mnz_d;
            s1_cls_q    <= s1_cls_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: apply rounding and class rules, register outputs
    // ------------------------------------------------------------------
    logic [TF32_MAN_W-1:0] w_rnd_man;
    logic                  w_rnd_carry;
    logic                  w_rnd_inexact;
    logic [EXP_W-1:0]      w_exp_out;
    logic [TF32_W-1:0]     w_sat_word;

    tf32_rne_round u_rne_round (
        .i_man     (s1_man_q),
        .i_lsb     (s1_lsb_q),
        .i_guard   (s1_guard_q),
        .i_sticky  (s1_sticky_q),
        .o_man     (w_rnd_man),
        .o_carry   (w_rnd_carry),
        .o_inexact (w_rnd_inexact)
    );

    // Normal exponents are at most 0xFE, so the increment cannot wrap.
    assign w_exp_out  = s1_exp_q + {{(EXP_W-1){1'b0}}, w_rnd_carry};
    assign w_sat_word = {s1_sign_q, TF32_MAX_EXP, TF32_MAX_MAN};

    logic [TF32_W-1:0] out_data_q,    out_data_d;
    logic              out_inexact_q, out_inexact_d;
    logic              out_sat_q,     out_sat_d;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_inexact_d = out_inexact_q;
        out_sat_d     = out_sat_q;
        if (w_s2_en) begin
            out_valid_d = s1_valid_q;
        end
        if (w_s2_en && s1_valid_q) begin
            case (s1_cls_q)
                CLS_ZERO: begin
                    out_data_d    = TF32_POS_ZERO;
                    out_data_d[TF32_W-1] = KEEP_ZERO_SIGN ? s1_sign_q : 1'b0;
                    out_inexact_d = s1_mnz_q;
                    out_sat_d     = 1'b0;
                end
                CLS_SPECIAL: begin
                    out_data_d    = w_sat_word;
                    out_inexact_d = 1'b1;
                    out_sat_d     = 1'b1;
                end
                default: begin
                    if (w_exp_out == '1) begin
                        out_data_d    = w_sat_word;
                        out_inexact_d = 1'b1;
                        out_sat_d     = 1'b1;
                    end else begin
                        out_data_d    = {s1_sign_q, w_exp_out, w_rnd_man};
                        out_inexact_d = w_rnd_inexact;
                        out_sat_d     = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_inexact_q <= 1'b0;
            out_sat_q     <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_inexact_q <= out_inexact_d;
            out_sat_q     <= out_sat_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_inexact = out_inexact_q;
    assign out_sat     = out_sat_q;

`ifdef TF32_CVT_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters; clear wins over increment
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_words_q,   cnt_words_d;
    logic [CNT_W-1:0] cnt_inexact_q, cnt_inexact_d;
    logic [CNT_W-1:0] cnt_sat_q,     cnt_sat_d;
    logic             w_out_hs;

    assign w_out_hs = out_valid_q && out_ready;

    always_comb begin
        cnt_words_d   = cnt_words_q;
        cnt_inexact_d = cnt_inexact_q;
        cnt_sat_d     = cnt_sat_q;
        if (cnt_clr) begin
            cnt_words_d   = '0;
            cnt_inexact_d = '0;
            cnt_sat_d     = '0;
        end else if (w_out_hs) begin
            if (cnt_words_q != '1) begin
                cnt_words_d = cnt_words_q + CNT_W'(1);
            end
            if (out_inexact_q && (cnt_inexact_q != '1)) begin
                cnt_inexact_d = cnt_inexact_q + CNT_W'(1);
            end
            if (out_sat_q && (cnt_sat_q != '1)) begin
                cnt_sat_d = cnt_sat_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_words_q   <= '0;
            cnt_inexact_q <= '0;
            cnt_sat_q     <= '0;
        end else begin
            cnt_words_q   <= cnt_words_d;
            cnt_inexact_q <= cnt_inexact_d;
            cnt_sat_q     <= cnt_sat_d;
        end
    end

    assign cnt_words   = cnt_words_q;
    assign cnt_inexact = cnt_inexact_q;
    assign cnt_sat     = cnt_sat_q;
`endif

endmodule : tf32_from_fp32_cvt
`default_nettype wire

// File: tb/tb_tf32_from_fp32_cvt.sv
`default_nettype none
// ============================================================================
// Module      : tb_tf32_from_fp32_cvt
// Description : Scoreboard bench for tf32_from_fp32_cvt. Two instances share
//               stimulus: KEEP_ZERO_SIGN=0 and KEEP_ZERO_SIGN=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tf32_from_fp32_cvt;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b1;
    logic        in_ready, in_ready_1;
    logic        out_valid, out_valid_1;
    logic [18:0] out_data, out_data_1;
    logic        out_inexact, out_inexact_1;
    logic        out_sat, out_sat_1;
`ifdef TF32_CVT_STATS_EN
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] cnt_words, cnt_inexact, cnt_sat;
    logic [CNT_W-1:0] cnt_words_1, cnt_inexact_1, cnt_sat_1;
    int               m_words, m_inx, m_sat;
`endif

    always #5 clk = ~clk;

    tf32_from_fp32_cvt #(.CNT_W(CNT_W), .KEEP_ZERO_SIGN(1'b0)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_inexact(out_inexact),
`ifdef TF32_CVT_STATS_EN
        .cnt_clr(cnt_clr), .cnt_words(cnt_words),
        .cnt_inexact(cnt_inexact), .cnt_sat(cnt_sat),
`endif
        .out_sat(out_sat)
    );

    tf32_from_fp32_cvt #(.CNT_W(CNT_W), .KEEP_ZERO_SIGN(1'b1)) u_dut_kz (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_1), .in_data(in_data),
        .out_valid(out_valid_1), .out_ready(out_ready), .out_data(out_data_1),
        .out_inexact(out_inexact_1),
`ifdef TF32_CVT_STATS_EN
        .cnt_clr(cnt_clr), .cnt_words(cnt_words_1),
        .cnt_inexact(cnt_inexact_1), .cnt_sat(cnt_sat_1),
`endif
        .out_sat(out_sat_1)
    );

    typedef struct {
        logic [18:0] d0;
        logic [18:0] d1;
        logic        inx;
        logic        sat;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] vec[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          accepted;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, want, cyc);
        end
    endtask

    // Reference: {sat, inexact, tf32[18:0]}
    function automatic logic [20:0] ref_cvt(input logic [31:0] x, input bit kz);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [12:0] rem;
        logic [17:0] mag;
        bit          up;
        s   = x[31];
        e   = x[30:23];
        m   = x[22:0];
        rem = m[12:0];
        if (e == 8'h00) return {1'b0, (m != 0), (kz ? s : 1'b0), 18'h0};
        if (e == 8'hFF) return {1'b1, 1'b1, s, 8'hFE, 10'h3FF};
        up  = (rem > 13'h1000) || ((rem == 13'h1000) && m[13]);
        mag = {e, m[22:13]} + 18'(up);
        if (mag[17:10] == 8'hFF) return {1'b1, 1'b1, s, 8'hFE, 10'h3FF};
        return {1'b0, (rem != 0), s, mag};
    endfunction

    // One clock: check/score at negedge, then return #1 after the next posedge.
    task automatic step();
        bit   want_ov;
        exp_t e;
        logic [20:0] r0, r1;
        @(negedge clk);
        accepted = 1'b0;
        if (rst) begin
            sb.delete();
`ifdef TF32_CVT_STATS_EN
            m_words = 0; m_inx = 0; m_sat = 0;
`endif
        end else begin
            chk("in_ready", in_ready, !((sb.size() == 2) && !out_ready));
            chk("in_ready_kz", in_ready_1, !((sb.size() == 2) && !out_ready));
            want_ov = (sb.size() > 0) && ((cyc - sb[0].cyc) >= 2);
            chk("out_valid", out_valid, want_ov);
            chk("out_valid_kz", out_valid_1, want_ov);
            if (want_ov && out_valid) begin
                chk("out_data", out_data, sb[0].d0);
                chk("out_data_kz", out_data_1, sb[0].d1);
                chk("out_inexact", out_inexact, sb[0].inx);
                chk("out_sat", out_sat, sb[0].sat);
            end
`ifdef TF32_CVT_STATS_EN
            chk("cnt_words", cnt_words, m_words);
            chk("cnt_inexact", cnt_inexact, m_inx);
            chk("cnt_sat", cnt_sat, m_sat);
            if (cnt_clr) begin
                m_words = 0; m_inx = 0; m_sat = 0;
            end else if (want_ov && out_ready) begin
                if (m_words < 15) m_words++;
                if (sb[0].inx && m_inx < 15) m_inx++;
                if (sb[0].sat && m_sat < 15) m_sat++;
            end
`endif
            if (want_ov && out_ready) void'(sb.pop_front());
            if (in_valid && in_ready) begin
                r0    = ref_cvt(in_data, 1'b0);
                r1    = ref_cvt(in_data, 1'b1);
                e.d0  = r0[18:0];
                e.d1  = r1[18:0];
                e.inx = r0[19];
                e.sat = r0[20];
                e.cyc = cyc;
                sb.push_back(e);
                accepted = 1'b1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Stream vec[]; out_ready low on relative cycles lo..hi, or random when rnd.
    task automatic run_stream(input int lo, input int hi, input bit rnd);
        int idx = 0;
        int c   = 0;
        while ((idx < vec.size() || sb.size() != 0) && c < 2000) begin
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !((c >= lo) && (c <= hi));
            in_valid  = (idx < vec.size()) && (!rnd || ($urandom_range(0, 4) != 0));
            in_data   = (idx < vec.size()) ? vec[idx] : 32'h0;
`ifdef TF32_CVT_STATS_EN
            cnt_clr   = rnd && ($urandom_range(0, 60) == 0);
`endif
            step();
            if (accepted) idx++;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef TF32_CVT_STATS_EN
        cnt_clr   = 1'b0;
`endif
        chk("stream_done", (c < 2000), 1);
    endtask

    task automatic chk_reset_state();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_inexact", out_inexact, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef TF32_CVT_STATS_EN
        chk("rst_cnt_words", cnt_words, 0);
`endif
    endtask

    initial begin
        logic [7:0] e;
        // Reset
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk_reset_state();

        // Directed values, back-to-back with no stalls
        vec = '{32'h3F800000, 32'h3F801000, 32'h3F803000, 32'h3FFFF000,
                32'hBF800000, 32'h7F7FF000, 32'h7F800000, 32'hFFC00000,
                32'h80000000, 32'h00400000, 32'h00000000, 32'h807FFFFF,
                32'h3F800FFF, 32'h3F801001, 32'hFF7FF000, 32'h00800000};
        run_stream(0, -1, 1'b0);

        // Backpressure: 6 words, out_ready low for relative cycles 3..7
        vec = '{32'h40000000, 32'h40400000, 32'h40800000,
                32'h40A00000, 32'h40C00000, 32'h40E00000};
        run_stream(3, 7, 1'b0);

        // Random traffic with random stalls and boundary-heavy exponents
        vec.delete();
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0:       e = 8'h00;
                1:       e = 8'hFF;
                2:       e = 8'hFE;
                3:       e = 8'h01;
                default: e = 8'($urandom_range(0, 255));
            endcase
            vec.push_back({1'($urandom_range(0, 1)), e,
                           ($urandom_range(0, 2) == 0) ? {10'($urandom), 13'h1000}
                                                       : 23'($urandom)});
        end
        run_stream(0, -1, 1'b1);

        // Reset with two words in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h3F800000; step();
        in_data   = 32'hC0000000; step();
        in_valid  = 1'b0;         step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_state();
        out_ready = 1'b1;
        repeat (5) step();

        // Traffic resumes after reset
        vec = '{32'h3F803000, 32'h80000000};
        run_stream(0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_tf32_from_fp32_cvt
`default_nettype wire
